data_mem_param: RTL and testbench
=================================

Name: data_mem_param

Overview:
- Parametrised next-generation data memory for the RV32I core.
- Word-organised block RAM of configurable depth. Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Memory-mapped LED register of configurable width and address; reads of that address return the register value.
- New in this generation: misaligned-access detection with an error pulse, asynchronous reset, and configurable init file.
- Sits between the core's MEM stage and block RAM. Holds the pipeline via clk_stall.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- IDX_W, $clog2(DEPTH_WORDS), word-index width (derived; do not override).
- LED_ADDR, 32'h2000, byte address of the LED register.
- LED_W, 8, number of LED outputs (1..32).
- INIT_FILE, "verilog/program.hex", $readmemh image; empty string means no preload.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- addr  in  32  byte address
- write_data  in  32  store data, right-aligned
- memwrite  in  1  store request
- memread  in  1  load request
- sign_mask  in  4  [3]=signed load; [2:0]: 001 byte, 011 half, 111 word
- read_data  out  32  load result, extended
- led  out  LED_W  led_reg[LED_W-1:0]
- clk_stall  out  1  high while an access is in flight
- misalign_err  out  1  one-cycle pulse on a misaligned request

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE
  - clk_stall=0, misalign_err=0, read_data=0, led_reg=0
  - all request buffers cleared
  - RAM contents untouched; an in-flight write is dropped.
- State machine: IDLE, READ_BUFFER, READ, WRITE, FAULT.
- IDLE:
  - Every cycle, capture addr, write_data, memread, memwrite and sign_mask into buffers.
  - If memread|memwrite: misaligned requests go to FAULT; otherwise go to READ_BUFFER. Either way, clk_stall<=1.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- READ_BUFFER:
  - word_buf <= RAM[addr_buf[IDX_W+1:2]], or led_reg zero-extended when addr_buf==LED_ADDR.
  - Then go to READ if memread_buf, else WRITE. Read wins when both are set.
- READ:
  - read_data <= extract(word_buf, offset, size, signed); clk_stall<=0; go to IDLE.
- WRITE:
  - merged = word_buf with the selected byte/half lanes replaced from write_data_buffer, or the full word for word stores.
  - If addr_buf==LED_ADDR: led_reg<=merged and the RAM is not written. Otherwise RAM[idx]<=merged.
  - clk_stall<=0; go to IDLE.
- FAULT:
  - misalign_err<=1 for exactly this cycle's output; clk_stall<=0; go to IDLE.
  - No RAM, led_reg or read_data change.
- Latency: request seen in IDLE → clk_stall high for 2 cycles (READ_BUFFER, READ/WRITE) → read_data valid on the clock edge that drops clk_stall. A fault stalls for 1 cycle.
- Extraction:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Signed loads replicate the lane MSB; unsigned loads zero-fill.
- Address wrap: bits above IDX_W+1 are ignored for RAM indexing (aliasing), except for the exact LED_ADDR match.
- A new request while not IDLE is ignored; the core is stalled, so none is expected.
- Back-to-back: a store followed by a load to the same word in the next IDLE returns the new data, since the RAM write completes before the next READ_BUFFER.

Decomposition:
- Package data_mem_pkg holds:
  - state encoding localparams (IDLE..FAULT)
  - size codes SZ_BYTE=3'b001, SZ_HALF=3'b011, SZ_WORD=3'b111
  - a default LED_ADDR constant.
- Sub-module lsu_align (purely combinational). Inputs: word_buf, offset, sign_mask, write_data. Outputs: extended load data, merged store word, misaligned flag. The top level keeps the FSM, buffers, RAM and led_reg.

Test Plan:
- Reset mid-WRITE (assert reset in the WRITE cycle) → clk_stall=0 immediately, led=0, target word keeps its old value, next access works normally.
- sw 0x8899AABB @0x10, then lb @0x13 signed → 0xFFFFFF88; lbu @0x12 → 0x00000099; lh @0x10 → 0xFFFFAABB; lw → 0x8899AABB; each load stalls 2 cycles.
- sb 0x5A @0x11 over word 0x11223344 → 0x11225A44; sh 0xBEEF @0x12 → 0xBEEF5A44.
- lw @0x06 → misalign_err single-cycle pulse, clk_stall 1 cycle, read_data unchanged. sh @0x03 → pulse, RAM word unchanged.
- sw 0x000000A5 @LED_ADDR → led=8'hA5, RAM word at index (LED_ADDR>>2) unchanged. lw @LED_ADDR → 0x000000A5.
- DEPTH_WORDS=256: sw 0xCAFEF00D @0x400 then lw @0x000 → 0xCAFEF00D (wrap). memread=memwrite=1 → load performed, no write.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the RV32I data memory and its lane aligner.
package data_mem_pkg;

  // Access sequencer states.
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_BUFFER = 3'd1,
    READ        = 3'd2,
    WRITE       = 3'd3,
    FAULT       = 3'd4
  } state_t;

  // Access size codes carried in sign_mask[2:0].
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  // Default byte address of the memory-mapped LED register.
  localparam logic [31:0] DEFAULT_LED_ADDR = 32'h0000_2000;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte/halfword lane logic: load extraction with sign or zero
// extension, store lane merging, and misalignment detection.
module lsu_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_buf,
  input  logic [1:0]  offset,
  input  logic [3:0]  sign_mask,
  input  logic [31:0] write_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        misaligned
);

  logic [2:0]  size;
  logic        is_signed;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lane, extend it for loads and splice it in for stores.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    size       = sign_mask[2:0];
    is_signed  = sign_mask[3];
    byte_lane  = word_buf[{offset, 3'b000} +: 8];
    half_lane  = offset[1] ? word_buf[31:16] : word_buf[15:0];
    load_data  = word_buf;
    store_word = write_data;
    misaligned = |offset;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & byte_lane[7]}}, byte_lane};
        store_word = word_buf;
        store_word[{offset, 3'b000} +: 8] = write_data[7:0];
        misaligned = 1'b0;
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & half_lane[15]}}, half_lane};
        store_word = word_buf;
        if (offset[1]) store_word[31:16] = write_data[15:0];
        else           store_word[15:0]  = write_data[15:0];
        misaligned = offset[0];
      end
      SZ_WORD: ;
      default: ;  // undefined size codes behave as word accesses
    endcase
  end

endmodule

// File: rtl/data_mem_param.sv
// Parametrised RV32I data memory: word-organised RAM behind a small access
// sequencer, byte/half/word loads and stores, memory-mapped LED register,
// misaligned-access fault pulse, and pipeline hold via clk_stall.
module data_mem_param
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          IDX_W       = $clog2(DEPTH_WORDS),
  parameter logic [31:0] LED_ADDR    = DEFAULT_LED_ADDR,
  parameter int          LED_W       = 8,
  parameter string       INIT_FILE   = "verilog/program.hex"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             memwrite,
  input  logic             memread,
  input  logic [3:0]       sign_mask,
  output logic [31:0]      read_data,
  output logic [LED_W-1:0] led,
  output logic             clk_stall,
  output logic             misalign_err
);

  state_t state, next_state;

  logic [31:0]      addr_buf, write_data_buf, word_buf;
  logic             memread_buf, memwrite_buf;
  logic [3:0]       sign_mask_buf;
  logic [LED_W-1:0] led_reg;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             led_hit;
  logic [31:0]      led_ext;
  logic [1:0]       align_off;
  logic [3:0]       align_mask;
  logic [31:0]      load_data, store_word;
  logic             misaligned;
  logic             ram_we;

  // Upper address bits alias onto the RAM; only the exact LED address escapes.
  assign idx     = addr_buf[IDX_W+1:2];
  assign led_hit = (addr_buf == LED_ADDR);
  assign led     = led_reg;
  assign ram_we  = (state == WRITE) && !led_hit;

  // The aligner judges the live request in IDLE and the buffered one afterwards.
  assign align_off  = (state == IDLE) ? addr[1:0] : addr_buf[1:0];
  assign align_mask = (state == IDLE) ? sign_mask : sign_mask_buf;

  lsu_align u_align (
    .word_buf   (word_buf),
    .offset     (align_off),
    .sign_mask  (align_mask),
    .write_data (write_data_buf),
    .load_data  (load_data),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  // Zero-extend the LED register so it can stand in for a RAM word.
  always_comb begin
    led_ext = '0;
    led_ext[LED_W-1:0] = led_reg;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is assigned with '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode: fault or buffered access on a request, then read wins.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (memread | memwrite) next_state = misaligned ? FAULT : READ_BUFFER;
      READ_BUFFER: next_state = memread_buf ? READ : (memwrite_buf ? WRITE : IDLE);
      READ:        next_state = IDLE;
      WRITE:       next_state = IDLE;
      FAULT:       next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Request buffers, fetched word, load result, LED register and handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_buf       <= '0;
      write_data_buf <= '0;
      memread_buf    <= 1'b0;
      memwrite_buf   <= 1'b0;
      sign_mask_buf  <= '0;
      word_buf       <= '0;
      read_data      <= '0;
      led_reg        <= '0;
      clk_stall      <= 1'b0;
      misalign_err   <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          addr_buf       <= addr;
          write_data_buf <= write_data;
          memread_buf    <= memread;
          memwrite_buf   <= memwrite;
          sign_mask_buf  <= sign_mask;
          if (memread | memwrite) clk_stall <= 1'b1;
        end
        READ_BUFFER: begin
          word_buf <= led_hit ? led_ext : mem[idx];
          if (!memread_buf && !memwrite_buf) clk_stall <= 1'b0;
        end
        READ: begin
          read_data <= load_data;
          clk_stall <= 1'b0;
        end
        WRITE: begin
          if (led_hit) led_reg <= store_word[LED_W-1:0];
          clk_stall <= 1'b0;
        end
        FAULT: begin
          misalign_err <= 1'b1;
          clk_stall    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto block RAM; a write
    // interrupted by reset is dropped because the state is forced to IDLE.
    if (ram_we) mem[idx] <= store_word;
  end

endmodule

// File: tb/tb_data_mem_param.sv
// Scoreboard bench for data_mem_param: the driver computes expected responses
// from a byte-level memory model and queues them; a monitor compares each
// completed access (falling clk_stall) against the queue head.
module tb_data_mem_param;

  localparam int          DEPTH = 256;
  localparam logic [31:0] LED_A = 32'h0000_2000;
  localparam int          LEDW  = 8;

  localparam logic [3:0] M_LB  = 4'b1001;
  localparam logic [3:0] M_LBU = 4'b0001;
  localparam logic [3:0] M_LH  = 4'b1011;
  localparam logic [3:0] M_LW  = 4'b0111;
  localparam logic [3:0] M_SB  = 4'b0001;
  localparam logic [3:0] M_SH  = 4'b0011;
  localparam logic [3:0] M_SW  = 4'b0111;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     addr = '0;
  logic [31:0]     write_data = '0;
  logic            memwrite = 1'b0;
  logic            memread = 1'b0;
  logic [3:0]      sign_mask = '0;
  logic [31:0]     read_data;
  logic [LEDW-1:0] led;
  logic            clk_stall;
  logic            misalign_err;

  data_mem_param #(
    .DEPTH_WORDS (DEPTH),
    .LED_ADDR    (LED_A),
    .LED_W       (LEDW),
    .INIT_FILE   ("")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .write_data   (write_data),
    .memwrite     (memwrite),
    .memread      (memread),
    .sign_mask    (sign_mask),
    .read_data    (read_data),
    .led          (led),
    .clk_stall    (clk_stall),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] led;
    bit          fault;
    int          stall;
  } exp_t;

  exp_t            sb_q[$];
  logic [31:0]     model_mem [DEPTH];
  logic [31:0]     model_rd = '0;
  logic [LEDW-1:0] model_led = '0;
  int              vectors = 0;
  int              miscompares = 0;
  bit              in_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compute the expected response, queue it, then drive one request and wait
  // (bounded) for the access to finish. Returns at a negedge with the DUT idle.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input bit rd, input bit wr, input logic [3:0] m);
    exp_t        e;
    int          sz, off;
    logic [31:0] word, val, lane_mask;
    bit          done;
    sz  = (m[2:0] == 3'b001) ? 1 : (m[2:0] == 3'b011) ? 2 : 4;
    off = int'(a[1:0]);
    word = (a == LED_A) ? 32'(model_led) : model_mem[(a >> 2) % DEPTH];
    e.rd = model_rd;
    e.led = 32'(model_led);
    e.fault = 1'b0;
    e.stall = 2;
    if ((off % sz) != 0) begin
      e.fault = 1'b1;
      e.stall = 1;
    end else if (rd) begin
      val = word >> (8 * off);
      if (sz < 4) begin
        lane_mask = (32'h1 << (8 * sz)) - 32'h1;
        val = val & lane_mask;
        if (m[3] && val[8*sz-1]) val = val | ~lane_mask;
      end
      model_rd = val;
      e.rd = val;
    end else if (wr) begin
      for (int i = 0; i < sz; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      if (a == LED_A) begin
        model_led = word[LEDW-1:0];
        e.led = 32'(model_led);
      end else begin
        model_mem[(a >> 2) % DEPTH] = word;
      end
    end
    sb_q.push_back(e);

    addr = a; write_data = wd; memread = rd; memwrite = wr; sign_mask = m;
    @(posedge clk);
    #1;
    memread = 1'b0;
    memwrite = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      if (!clk_stall) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL access_timeout: clk_stall still high for addr %08h", a);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] m);
    issue(a, 32'h0, 1'b1, 1'b0, m);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    issue(a, d, 1'b0, 1'b1, m);
  endtask

  // Monitor: a falling clk_stall marks a completed access.
  initial begin : monitor
    int   stall_cnt;
    bit   pulse_chk;
    exp_t e;
    stall_cnt = 0;
    pulse_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        stall_cnt = 0;
        pulse_chk = 1'b0;
        continue;
      end
      if (pulse_chk) begin
        check("err_pulse_end", 32'(misalign_err), 32'h0);
        pulse_chk = 1'b0;
      end
      if (clk_stall) begin
        stall_cnt++;
      end else if (stall_cnt != 0) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: access finished with nothing queued at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("stall_len", 32'(stall_cnt), 32'(e.stall));
          check("misalign_err", 32'(misalign_err), 32'(e.fault));
          check("read_data", read_data, e.rd);
          check("led", 32'(led), e.led);
          pulse_chk = e.fault;
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a, d;
    logic [3:0]  m;
    int          op, szsel, sz;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_clk_stall", 32'(clk_stall), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'h0);
    reset = 1'b0;
    in_reset = 1'b0;

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < DEPTH; i++) store(32'(i * 4), $urandom, M_SW);

    // LED register store/load; aliased RAM word 0 must be untouched.
    store(32'h0, 32'h0102_0304, M_SW);
    store(LED_A, 32'h0000_00A5, M_SW);
    load(LED_A, M_LW);
    load(32'h0, M_LW);

    // Reset asserted during the WRITE cycle of a store.
    store(32'h40, 32'h1122_3344, M_SW);
    addr = 32'h40; write_data = 32'hDEAD_BEEF; memwrite = 1'b1; memread = 1'b0; sign_mask = M_SW;
    @(posedge clk);
    #1 memwrite = 1'b0;
    @(posedge clk);
    #2;
    check("stall_in_write", 32'(clk_stall), 32'h1);
    in_reset = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_mid_stall", 32'(clk_stall), 32'h0);
    check("rst_mid_led", 32'(led), 32'h0);
    check("rst_mid_read_data", read_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_reset = 1'b0;
    sb_q.delete();
    model_led = '0;
    model_rd = '0;
    load(32'h40, M_LW);

    // Extraction on a known word.
    store(32'h10, 32'h8899_AABB, M_SW);
    load(32'h13, M_LB);
    load(32'h12, M_LBU);
    load(32'h10, M_LH);
    load(32'h10, M_LW);

    // Sub-word stores merging into a word, back-to-back with the load.
    store(32'h10, 32'h1122_3344, M_SW);
    store(32'h11, 32'h0000_005A, M_SB);
    load(32'h10, M_LW);
    store(32'h12, 32'h0000_BEEF, M_SH);
    load(32'h10, M_LW);

    // Misaligned accesses fault without side effects.
    load(32'h06, M_LW);
    store(32'h03, 32'h0000_FFFF, M_SH);
    load(32'h00, M_LW);

    // Address wrap and read-wins when both strobes are set.
    store(32'h400, 32'hCAFE_F00D, M_SW);
    load(32'h000, M_LW);
    issue(32'h10, 32'hFFFF_FFFF, 1'b1, 1'b1, M_LW);
    load(32'h10, M_LW);

    // Randomised mix checked against the model.
    for (int k = 0; k < 300; k++) begin
      szsel = $urandom_range(0, 2);
      case (szsel)
        0:       begin m = 4'b0001; sz = 1; end
        1:       begin m = 4'b0011; sz = 2; end
        default: begin m = 4'b0111; sz = 4; end
      endcase
      m[3] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = LED_A | 32'($urandom_range(0, 3));
      else                           a = $urandom;
      if ($urandom_range(0, 9) < 7) a = a & ~32'(sz - 1);
      d  = $urandom;
      op = $urandom_range(0, 2);
      issue(a, d, (op != 1), (op != 0), m);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
